// File: rtl/aes_key_expand_ctrl.sv
// AES-128 key-expansion sequencer: emits round keys 0..10 over a valid/ready handshake.
// Optional round-key store for random-access reads is enabled by defining AES_RK_STORE_EN.
module aes_key_expand_ctrl #(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_W-1:0]   key_in,
    input  logic               key_valid,
    output logic               key_ready,
    input  logic               abort,
    output logic [KEY_W-1:0]   rk_data,
    output logic [3:0]         rk_idx,
    output logic               rk_valid,
    input  logic               rk_ready,
    output logic               done,
    input  logic [3:0]         rd_idx,
    output logic [KEY_W-1:0]   rd_key
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EMIT = 2'd1;
    localparam logic [1:0] S_STEP = 2'd2;
    localparam logic [3:0] LAST_IDX = 4'(NR);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    // Byte S-box: multiplicative inverse as x^254 in GF(2^8), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] inv;
        p   = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [1:0]       state_q, state_d;
    logic [KEY_W-1:0] rk_data_q, rk_data_d;
    logic [3:0]       rk_idx_q, rk_idx_d;
    logic             done_q, done_d;

    logic [31:0]      w0, w1, w2, w3, rot_w, sub_w, t_w, n0, n1, n2, n3;
    logic [3:0]       rnd_next;
    logic [KEY_W-1:0] next_key;

    assign w0       = rk_data_q[127:96];
    assign w1       = rk_data_q[95:64];
    assign w2       = rk_data_q[63:32];
    assign w3       = rk_data_q[31:0];
    assign rot_w    = {w3[23:0], w3[31:24]};
    assign rnd_next = rk_idx_q + 4'd1;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sub
            assign sub_w[gi*8 +: 8] = sbox(rot_w[gi*8 +: 8]);
        end
    endgenerate

    assign t_w      = sub_w ^ {rcon(rnd_next), 24'h000000};
    assign n0       = w0 ^ t_w;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    always_comb begin
        state_d   = state_q;
        rk_data_d = rk_data_q;
        rk_idx_d  = rk_idx_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (key_valid) begin
                    rk_data_d = key_in;
                    rk_idx_d  = 4'd0;
                    state_d   = S_EMIT;
                end
            end
            S_EMIT: begin
                if (rk_ready) begin
                    if (rk_idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_STEP;
                    end
                end
            end
            S_STEP: begin
                rk_data_d = next_key;
                rk_idx_d  = rnd_next;
                state_d   = S_EMIT;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides any handshake in flight and scrubs the key material.
        if (abort && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            rk_data_d = '0;
            rk_idx_d  = 4'd0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rk_data_q <= '0;
            rk_idx_q  <= 4'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rk_data_q <= rk_data_d;
            rk_idx_q  <= rk_idx_d;
            done_q    <= done_d;
        end
    end

    assign key_ready = (state_q == S_IDLE);
    assign rk_valid  = (state_q == S_EMIT);
    assign rk_data   = rk_data_q;
    assign rk_idx    = rk_idx_q;
    assign done      = done_q;

`ifdef AES_RK_STORE_EN
    logic [KEY_W-1:0] store_q [0:NR];
    logic             store_wr_en;
    logic             store_clr;

    assign store_wr_en = (state_d == S_EMIT) && (state_q != S_EMIT);
    assign store_clr   = abort && (state_q != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NR; i++) store_q[i] <= '0;
        end else if (store_clr) begin
            for (int i = 0; i <= NR; i++) store_q[i] <= '0;
        end else if (store_wr_en) begin
            store_q[rk_idx_d] <= rk_data_d;
        end
    end

    assign rd_key = (rd_idx <= LAST_IDX) ? store_q[rd_idx] : '0;
`else
    logic unused_rd_idx;
    assign unused_rd_idx = ^rd_idx;
    assign rd_key        = '0;
`endif

endmodule
